// File: rtl/barrido_anodos_display.sv
`default_nettype none
// ============================================================================
// Module      : barrido_anodos_display
// Description : Scan controller for a 4-digit 7-segment display. Drives the
//               digit index for the decoder and the matching active-low anode
//               enables, with an optional blanking gap between digits to
//               suppress ghosting.
// Revision    : 1.0 - initial release
// ============================================================================
module barrido_anodos_display #(
  parameter int CNT_WIDTH    = 17,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       habilitar,
  output logic [1:0] seleccion,
  output logic [3:0] anodos,
  output logic       tick_digito
);

  typedef enum logic [0:0] {
    MOSTRAR = 1'b0,
    APAGAR  = 1'b1
  } estado_t;

  // Terminal counts of each phase. With no gap, the APAGAR terminal is never used.
  localparam logic [CNT_WIDTH-1:0] c_ult_mostrar = CNT_WIDTH'(REFRESH_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] c_ult_apagar  =
    CNT_WIDTH'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] c_uno         = CNT_WIDTH'(1);
  localparam logic                 c_con_hueco   = (BLANK_CYCLES > 0);
  localparam logic [3:0]           c_apagado     = 4'b1111;

  estado_t              r_estado, w_estado_n;
  logic [CNT_WIDTH-1:0] r_cnt,    w_cnt_n;
  logic [1:0]           r_sel,    w_sel_n;
  logic [3:0]           r_anodos, w_anodos_n;
  logic                 r_tick,   w_tick_n;

  // State, counter and all outputs are registered; reset blanks the display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= MOSTRAR;
      r_cnt    <= '0;
      r_sel    <= 2'd0;
      r_anodos <= c_apagado;
      r_tick   <= 1'b0;
    end else begin
      r_estado <= w_estado_n;
      r_cnt    <= w_cnt_n;
      r_sel    <= w_sel_n;
      r_anodos <= w_anodos_n;
      r_tick   <= w_tick_n;
    end
  end

  // Next-state logic; everything holds while habilitar is low. The anode
  // decode uses the next index so anodos and seleccion switch on the same edge.
  always_comb begin
    w_estado_n = r_estado;
    w_cnt_n    = r_cnt;
    w_sel_n    = r_sel;
    w_tick_n   = 1'b0;
    w_anodos_n = c_apagado;

    if (habilitar) begin
      case (r_estado)
        MOSTRAR: begin
          if (r_cnt == c_ult_mostrar) begin
            w_cnt_n = '0;
            if (c_con_hueco) begin
              w_estado_n = APAGAR;
            end else begin
              w_sel_n  = r_sel + 2'd1;
              w_tick_n = 1'b1;
            end
          end else begin
            w_cnt_n = r_cnt + c_uno;
          end
        end
        APAGAR: begin
          if (r_cnt == c_ult_apagar) begin
            w_cnt_n    = '0;
            w_estado_n = MOSTRAR;
            w_sel_n    = r_sel + 2'd1;
            w_tick_n   = 1'b1;
          end else begin
            w_cnt_n = r_cnt + c_uno;
          end
        end
        default: begin
          w_estado_n = MOSTRAR;
          w_cnt_n    = '0;
        end
      endcase

      if (w_estado_n == MOSTRAR) begin
        w_anodos_n = ~(4'b0001 << w_sel_n);
      end
    end
  end

  assign seleccion   = r_sel;
  assign anodos      = r_anodos;
  assign tick_digito = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_barrido_anodos_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrido_anodos_display
// Description : Directed/table-driven bench for barrido_anodos_display with
//               REFRESH_DIV=4, CNT_WIDTH=3, one instance with BLANK_CYCLES=2
//               and one with BLANK_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrido_anodos_display;

  typedef struct {
    logic       hab;
    logic [3:0] an;
    logic [1:0] sel;
    logic       tk;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       habilitar;
  logic [1:0] seleccion,  seleccion0;
  logic [3:0] anodos,     anodos0;
  logic       tick_digito, tick_digito0;

  int checks = 0;
  int errors = 0;

  barrido_anodos_display #(
    .CNT_WIDTH(3), .REFRESH_DIV(4), .BLANK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .habilitar(habilitar),
    .seleccion(seleccion), .anodos(anodos), .tick_digito(tick_digito)
  );

  barrido_anodos_display #(
    .CNT_WIDTH(3), .REFRESH_DIV(4), .BLANK_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .habilitar(habilitar),
    .seleccion(seleccion0), .anodos(anodos0), .tick_digito(tick_digito0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] an, input logic [1:0] sel,
                         input logic tk);
    chk({name, ".anodos"},      {28'd0, anodos},      {28'd0, an});
    chk({name, ".seleccion"},   {30'd0, seleccion},   {30'd0, sel});
    chk({name, ".tick_digito"}, {31'd0, tick_digito}, {31'd0, tk});
  endtask

  // One clock, then sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tab[30];
  int   lit_after;
  logic [1:0] prev_sel, prev_sel0;

  initial begin
    // T2 expected table, edge i+1 after reset release. The first digit shows
    // only 3 lit cycles because its cnt=0 cycle carries the reset anodos value.
    // After that: 2 dark cycles (old index), then 4 lit (new index, tick first).
    for (int i = 1; i <= 30; i++) begin
      int j, slot, r;
      tab[i-1].hab = 1'b1;
      if (i < 4) begin
        tab[i-1].an = 4'b1110; tab[i-1].sel = 2'd0; tab[i-1].tk = 1'b0;
      end else begin
        j = i - 4; slot = j / 6; r = j % 6;
        if (r < 2) begin
          tab[i-1].an  = 4'b1111;
          tab[i-1].sel = 2'(slot % 4);
          tab[i-1].tk  = 1'b0;
        end else begin
          tab[i-1].sel = 2'((slot + 1) % 4);
          tab[i-1].an  = ~(4'b0001 << tab[i-1].sel);
          tab[i-1].tk  = (r == 2);
        end
      end
    end

    // ---- Reset state ----
    reset = 1'b1; habilitar = 1'b0;
    step();
    chk_out("reset", 4'b1111, 2'd0, 1'b0);

    // ---- T1: async reset mid-scan ----
    reset = 1'b0; habilitar = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("t1_prescan.seleccion", {30'd0, seleccion}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t1_async", 4'b1111, 2'd0, 1'b0);
    step();
    chk_out("t1_held", 4'b1111, 2'd0, 1'b0);

    // ---- T2: table-driven full frame ----
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      habilitar = tab[i].hab;
      step();
      chk_out($sformatf("t2[%0d]", i + 1), tab[i].an, tab[i].sel, tab[i].tk);
    end

    // ---- T3: habilitar drop at cnt=2 of digit 2 ----
    // Now at sel=1, cnt=0. Edges 31..33 lit, 34..35 dark, 36 new digit 2.
    for (int i = 31; i <= 38; i++) begin
      step();
      if (i == 36) chk_out("t3_digit2_start", 4'b1011, 2'd2, 1'b1);
    end
    chk_out("t3_cnt2", 4'b1011, 2'd2, 1'b0);
    habilitar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("t3_frozen[%0d]", i), 4'b1111, 2'd2, 1'b0);
    end
    // Re-enable: the enabling cycle advances cnt 2->3 and relights on its
    // edge; cnt=3 is the only lit slot left before the gap.
    habilitar = 1'b1;
    lit_after = 0;
    step();
    chk_out("t3_relit", 4'b1011, 2'd2, 1'b0);
    if (anodos == 4'b1011) lit_after++;
    step();
    chk_out("t3_gap0", 4'b1111, 2'd2, 1'b0);
    if (anodos == 4'b1011) lit_after++;
    step();
    chk_out("t3_gap1", 4'b1111, 2'd2, 1'b0);
    step();
    chk_out("t3_digit3", 4'b0111, 2'd3, 1'b1);
    chk("t3_lit_after", lit_after, 32'd1);

    // ---- T4: no-gap instance ----
    reset = 1'b1;
    step();
    chk("t4_reset.anodos", {28'd0, anodos0}, 32'hF);
    reset = 1'b0; habilitar = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      logic [1:0] es;
      logic       et;
      step();
      if (i < 4) begin es = 2'd0; et = 1'b0; end
      else begin es = 2'(((i - 4) / 4 + 1) % 4); et = ((i - 4) % 4 == 0); end
      chk($sformatf("t4[%0d].anodos", i), {28'd0, anodos0}, {28'd0, ~(4'b0001 << es)});
      chk($sformatf("t4[%0d].seleccion", i), {30'd0, seleccion0}, {30'd0, es});
      chk($sformatf("t4[%0d].tick", i), {31'd0, tick_digito0}, {31'd0, et});
    end

    // ---- T5: random habilitar drops, invariant checks on both instances ----
    prev_sel  = seleccion;
    prev_sel0 = seleccion0;
    for (int i = 0; i < 300; i++) begin
      habilitar = ($urandom_range(0, 9) < 8);
      step();
      chk("t5_onehot", {31'd0, ($countones(~anodos) <= 1)}, 32'd1);
      chk("t5_onehot0", {31'd0, ($countones(~anodos0) <= 1)}, 32'd1);
      if (anodos != 4'b1111)
        chk("t5_idx", {28'd0, anodos}, {28'd0, ~(4'b0001 << seleccion)});
      if (anodos0 != 4'b1111)
        chk("t5_idx0", {28'd0, anodos0}, {28'd0, ~(4'b0001 << seleccion0)});
      chk("t5_tick", {31'd0, tick_digito}, {31'd0, (seleccion != prev_sel)});
      chk("t5_tick0", {31'd0, tick_digito0}, {31'd0, (seleccion0 != prev_sel0)});
      prev_sel  = seleccion;
      prev_sel0 = seleccion0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
